// File: rtl/sub86_bus_resp_pkg.sv
// Shared types and constants for the sub86 bus responder.
package sub86_bus_resp_pkg;

    typedef enum logic [3:0] {
        ST_SEL   = 4'd0,
        ST_FETCH = 4'd1,
        ST_RD_LO = 4'd2,
        ST_RD_HI = 4'd3,
        ST_PULSE = 4'd4,
        ST_WR_LO = 4'd5,
        ST_WR_HI = 4'd6
    } state_t;

    typedef enum logic [2:0] {
        SQ_IDLE = 3'd0,
        SQ_RD   = 3'd1,
        SQ_WSU  = 3'd2,
        SQ_WST  = 3'd3,
        SQ_WHD  = 3'd4
    } seq_t;

    localparam logic [1:0]  BEN_DWORD = 2'b01;
    localparam logic [1:0]  BEN_HALF  = 2'b11;
    localparam logic [15:0] ID_RESET  = 16'h9090;

    // 00 and 10 both mean byte
    function automatic logic is_byte(input logic [1:0] ben);
        return !ben[0];
    endfunction

endpackage

// File: rtl/sub86_bus_resp_sram_seq.sv
// SRAM access sequencer: wait counter plus OE/WE/byte-lane strobe timing.
module sub86_sram_seq
    import sub86_bus_resp_pkg::*;
#(
    parameter int AW       = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    be_n,
    input  logic [15:0]   bus_data,
    output logic          done,
    output logic [15:0]   rdata,
    output logic [AW-1:0] sa,
    output logic [15:0]   sdq_o,
    output logic          sdq_oe,
    output logic          soe_n,
    output logic          swe_n,
    output logic [1:0]    sbe_n
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    seq_t       phase;
    logic [3:0] cnt;

    assign done  = (phase == SQ_RD && cnt == 4'd0) || phase == SQ_WHD;
    assign rdata = bus_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= SQ_IDLE;
            cnt    <= '0;
            sa     <= '0;
            sdq_o  <= '0;
            sdq_oe <= 1'b0;
            soe_n  <= 1'b1;
            swe_n  <= 1'b1;
            sbe_n  <= 2'b11;
        end else if (start) begin
            // start is only raised when idle or on the done cycle, so accesses chain back-to-back
            sa    <= addr;
            cnt   <= WAIT_INIT;
            swe_n <= 1'b1;
            if (we) begin
                phase  <= SQ_WSU;
                sdq_o  <= wdata;
                sdq_oe <= 1'b1;
                soe_n  <= 1'b1;
                sbe_n  <= be_n;
            end else begin
                phase  <= SQ_RD;
                sdq_oe <= 1'b0;
                soe_n  <= 1'b0;
                sbe_n  <= 2'b00;
            end
        end else begin
            case (phase)
                SQ_RD: begin
                    if (cnt == 4'd0) begin
                        phase <= SQ_IDLE;
                        soe_n <= 1'b1;
                        sbe_n <= 2'b11;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SQ_WSU: begin
                    phase <= SQ_WST;
                    swe_n <= 1'b0;
                end
                SQ_WST: begin
                    if (cnt == 4'd0) begin
                        phase <= SQ_WHD;
                        swe_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SQ_WHD: begin
                    phase  <= SQ_IDLE;
                    sdq_oe <= 1'b0;
                    sbe_n  <= 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sub86_bus_resp.sv
// sub86 bus responder: instruction fetch cache, data reads, posted writes, CE pacing.
module sub86_bus_resp
    import sub86_bus_resp_pkg::*;
#(
    parameter int AW        = 18,
    parameter int WAIT_CYC  = 1,
    parameter int ALWAYS_RD = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    output logic          CE,
    input  logic [31:0]   IA,
    output logic [15:0]   ID,
    input  logic [31:0]   A,
    output logic [31:0]   D,
    input  logic [31:0]   Q,
    input  logic          WEN,
    input  logic          RD,
    input  logic [1:0]    BEN,
    output logic [AW-1:0] SA,
    output logic [15:0]   SDQ_O,
    input  logic [15:0]   SDQ_I,
    output logic          SDQ_OE,
    output logic          SOE_N,
    output logic          SWE_N,
    output logic [1:0]    SBE_N
);

    state_t        state, nxt;
    logic          hit, rd_need;
    logic [1:0]    rd_size_in, rd_size;
    logic [AW-1:0] rd_base, rd_addr, tag, wr_addr;
    logic          tag_vld, wr_dword;
    logic [15:0]   lo_buf, wr_q_hi;
    logic          seq_start, seq_we, seq_done;
    logic [AW-1:0] seq_addr;
    logic [15:0]   seq_wdata, seq_rdata;
    logic [1:0]    seq_be_n;
    logic          unused_bits;

    assign unused_bits = ^{IA[31:AW+1], IA[0], A[31:AW+1]};
    assign hit        = tag_vld && (IA[AW:1] == tag);
    assign rd_need    = RD || (ALWAYS_RD != 0);
    assign rd_size_in = RD ? BEN : BEN_DWORD;
    assign rd_base    = (rd_size_in == BEN_DWORD) ? {A[AW:2], 1'b0} : A[AW:1];

    always_comb begin
        nxt = state;
        case (state)
            ST_SEL:   nxt = !hit ? ST_FETCH : (rd_need ? ST_RD_LO : ST_PULSE);
            ST_FETCH: if (seq_done) nxt = rd_need ? ST_RD_LO : ST_PULSE;
            ST_RD_LO: if (seq_done) nxt = (rd_size == BEN_DWORD) ? ST_RD_HI : ST_PULSE;
            ST_RD_HI: if (seq_done) nxt = ST_PULSE;
            ST_PULSE: nxt = !WEN ? ST_WR_LO : ST_SEL;
            ST_WR_LO: if (seq_done) nxt = wr_dword ? ST_WR_HI : ST_SEL;
            ST_WR_HI: if (seq_done) nxt = ST_SEL;
            default:  nxt = ST_SEL;
        endcase
    end

    // Each access state is left on done, so any entry into one launches exactly one access.
    // WR_LO is entered from PULSE, so it takes the core's live A/Q/BEN.
    always_comb begin
        seq_start = (nxt != state) &&
                    (nxt inside {ST_FETCH, ST_RD_LO, ST_RD_HI, ST_WR_LO, ST_WR_HI});
        seq_we    = nxt inside {ST_WR_LO, ST_WR_HI};
        seq_addr  = IA[AW:1];
        seq_wdata = Q[15:0];
        seq_be_n  = 2'b00;
        case (nxt)
            ST_RD_LO: seq_addr = rd_base;
            ST_RD_HI: seq_addr = rd_addr + 1'b1;
            ST_WR_LO: begin
                seq_addr = A[AW:1];
                if (is_byte(BEN)) begin
                    seq_wdata = {Q[7:0], Q[7:0]};
                    seq_be_n  = A[0] ? 2'b01 : 2'b10;
                end
            end
            ST_WR_HI: begin
                seq_addr  = wr_addr + 1'b1;
                seq_wdata = wr_q_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= ST_SEL;
            CE       <= 1'b0;
            ID       <= ID_RESET;
            D        <= '0;
            tag      <= '0;
            tag_vld  <= 1'b0;
            rd_addr  <= '0;
            rd_size  <= BEN_DWORD;
            lo_buf   <= '0;
            wr_addr  <= '0;
            wr_dword <= 1'b0;
            wr_q_hi  <= '0;
        end else begin
            state <= nxt;
            CE    <= (nxt == ST_PULSE);
            if (state == ST_FETCH && seq_done) begin
                ID      <= {seq_rdata[7:0], seq_rdata[15:8]};
                tag     <= IA[AW:1];
                tag_vld <= 1'b1;
            end
            if (nxt == ST_RD_LO && state != ST_RD_LO) begin
                rd_addr <= rd_base;
                rd_size <= rd_size_in;
            end
            if (state == ST_RD_LO && seq_done) begin
                if (rd_size == BEN_DWORD)
                    lo_buf <= seq_rdata;
                else if (is_byte(rd_size))
                    D <= {24'b0, A[0] ? seq_rdata[15:8] : seq_rdata[7:0]};
                else
                    D <= {16'b0, seq_rdata};
            end
            if (state == ST_RD_HI && seq_done)
                D <= {seq_rdata, lo_buf};
            if (state == ST_PULSE && !WEN) begin
                wr_addr  <= A[AW:1];
                wr_dword <= (BEN == BEN_DWORD);
                wr_q_hi  <= Q[31:16];
                tag_vld  <= 1'b0;
            end
        end
    end

    sub86_sram_seq #(.AW(AW), .WAIT_CYC(WAIT_CYC)) u_seq (
        .clk      (CLK),
        .rst_n    (RSTN),
        .start    (seq_start),
        .we       (seq_we),
        .addr     (seq_addr),
        .wdata    (seq_wdata),
        .be_n     (seq_be_n),
        .bus_data (SDQ_I),
        .done     (seq_done),
        .rdata    (seq_rdata),
        .sa       (SA),
        .sdq_o    (SDQ_O),
        .sdq_oe   (SDQ_OE),
        .soe_n    (SOE_N),
        .swe_n    (SWE_N),
        .sbe_n    (SBE_N)
    );

endmodule

// File: tb/tb_sub86_bus_resp.sv
// Directed bench for sub86_bus_resp with an SRAM model and read/write/fetch scoreboards.
module tb_sub86_bus_resp;

    localparam int AW = 18;

    typedef struct {
        logic [AW-1:0] sa;
        logic [15:0]   data;
        logic [1:0]    be_n;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ce;
    logic [31:0]   ia, a, d, q;
    logic [15:0]   id, sdq_o, sdq_i;
    logic          wen, rd, sdq_oe, soe_n, swe_n;
    logic [1:0]    ben, sbe_n;
    logic [AW-1:0] sa;

    logic [15:0] mem [0:(1<<AW)-1];
    wr_t         exp_wr [$];
    logic [31:0] exp_d  [$];
    logic [15:0] exp_id [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        swe_prev = 1'b1;

    sub86_bus_resp #(.AW(AW), .WAIT_CYC(1), .ALWAYS_RD(0)) dut (
        .CLK(clk), .RSTN(rstn), .CE(ce), .IA(ia), .ID(id), .A(a), .D(d), .Q(q),
        .WEN(wen), .RD(rd), .BEN(ben), .SA(sa), .SDQ_O(sdq_o), .SDQ_I(sdq_i),
        .SDQ_OE(sdq_oe), .SOE_N(soe_n), .SWE_N(swe_n), .SBE_N(sbe_n)
    );

    always #5 clk = ~clk;

    assign sdq_i = soe_n ? 16'h0000 : mem[sa];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SRAM write model and write scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (!swe_n) begin
            if (!sbe_n[0]) mem[sa][7:0]  = sdq_o[7:0];
            if (!sbe_n[1]) mem[sa][15:8] = sdq_o[15:8];
        end
        if (rstn) begin
            chk("oe_we_excl", 32'(soe_n | swe_n), 32'd1);
            if (!swe_n && swe_prev) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(sa), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_sa", 32'(sa), 32'(e.sa));
                    chk("wr_data", 32'(sdq_o), 32'(e.data));
                    chk("wr_sbe_n", 32'(sbe_n), 32'(e.be_n));
                    chk("wr_oe", 32'(sdq_oe), 32'd1);
                end
            end
        end
        swe_prev = swe_n;
    end

    task automatic wait_ce(output int cyc, output int soe_cnt, output logic [31:0] first_sa);
        cyc = 0; soe_cnt = 0; first_sa = 32'hFFFF_FFFF;
        do begin
            @(negedge clk);
            cyc++;
            if (!soe_n) begin
                if (soe_cnt == 0) first_sa = 32'(sa);
                soe_cnt++;
            end
        end while (!ce && cyc < 40);
        chk("ce_seen", 32'(ce), 32'd1);
    endtask

    task automatic next_step();
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, soe_cnt;
        logic [31:0] fsa;
        logic found;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[18'h10000] = 16'hE990;
        mem[18'h1D8FC] = 16'h5678;
        mem[18'h1D8FD] = 16'h1234;
        mem[18'h00080] = 16'hAB00;
        rstn = 1'b0; ia = 32'h20000; a = '0; q = '0; wen = 1'b1; rd = 1'b0; ben = 2'b11;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_swe_n", 32'(swe_n), 32'd1);
        chk("rst_soe_n", 32'(soe_n), 32'd1);
        chk("rst_sdq_oe", 32'(sdq_oe), 32'd0);
        chk("rst_sbe_n", 32'(sbe_n), 32'd3);
        chk("rst_id", 32'(id), 32'h9090);
        chk("rst_d", d, 32'd0);

        // fetch miss
        next_step();
        rstn = 1'b1;
        exp_id.push_back(16'h90E9);
        wait_ce(cyc, soe_cnt, fsa);
        chk("miss_cycles", 32'(cyc), 32'd4);
        chk("miss_fetch_sa", fsa, 32'h10000);
        chk("miss_soe_cycles", 32'(soe_cnt), 32'd2);
        chk("miss_id", 32'(id), 32'(exp_id.pop_front()));

        // fetch hit
        next_step();
        wait_ce(cyc, soe_cnt, fsa);
        chk("hit_cycles", 32'(cyc), 32'd2);
        chk("hit_soe_cycles", 32'(soe_cnt), 32'd0);

        // dword read
        next_step();
        rd = 1'b1; ben = 2'b01; a = 32'h3B1F8;
        exp_d.push_back(32'h12345678);
        wait_ce(cyc, soe_cnt, fsa);
        chk("rd32_cycles", 32'(cyc), 32'd6);
        chk("rd32_sa", fsa, 32'h1D8FC);
        chk("rd32_soe_cycles", 32'(soe_cnt), 32'd4);
        chk("rd32_d", d, exp_d.pop_front());

        // byte read, odd address selects high lane
        next_step();
        ben = 2'b00; a = 32'h101;
        exp_d.push_back(32'h000000AB);
        wait_ce(cyc, soe_cnt, fsa);
        chk("rd8_cycles", 32'(cyc), 32'd4);
        chk("rd8_sa", fsa, 32'h80);
        chk("rd8_d", d, exp_d.pop_front());

        // posted dword write, then refetch
        next_step();
        rd = 1'b0; wen = 1'b0; ben = 2'b01; a = 32'h3B1FC; q = 32'hDEADBEEF;
        exp_wr.push_back('{18'h1D8FE, 16'hBEEF, 2'b00});
        exp_wr.push_back('{18'h1D8FF, 16'hDEAD, 2'b00});
        wait_ce(cyc, soe_cnt, fsa);
        chk("wr32_pulse_cycles", 32'(cyc), 32'd2);
        next_step();
        wen = 1'b1;
        exp_id.push_back(16'h90E9);
        wait_ce(cyc, soe_cnt, fsa);
        chk("wr32_step_cycles", 32'(cyc), 32'd12);
        chk("wr32_refetch_sa", fsa, 32'h10000);
        chk("wr32_refetch_soe", 32'(soe_cnt), 32'd2);
        chk("wr32_refetch_id", 32'(id), 32'(exp_id.pop_front()));
        chk("wr32_all_seen", 32'(exp_wr.size()), 32'd0);
        chk("wr32_mem_lo", 32'(mem[18'h1D8FE]), 32'hBEEF);
        chk("wr32_mem_hi", 32'(mem[18'h1D8FF]), 32'hDEAD);

        // byte write to odd address touches only the high lane
        next_step();
        wen = 1'b0; ben = 2'b00; a = 32'h101; q = 32'h000000AB;
        exp_wr.push_back('{18'h00080, 16'hABAB, 2'b01});
        wait_ce(cyc, soe_cnt, fsa);
        chk("wr8_pulse_cycles", 32'(cyc), 32'd2);
        next_step();
        wen = 1'b1; rd = 1'b1; ben = 2'b11; a = 32'h100;
        exp_d.push_back(32'h0000AB00);
        exp_id.push_back(16'h90E9);
        wait_ce(cyc, soe_cnt, fsa);
        chk("wr8_step_cycles", 32'(cyc), 32'd10);
        chk("rd16_d", d, exp_d.pop_front());
        chk("rd16_id", 32'(id), 32'(exp_id.pop_front()));

        // reset during the WR_LO strobe
        next_step();
        rd = 1'b0; wen = 1'b0; ben = 2'b01; a = 32'h3B1FC; q = 32'hCAFEF00D;
        exp_wr.push_back('{18'h1D8FE, 16'hF00D, 2'b00});
        wait_ce(cyc, soe_cnt, fsa);
        chk("rstwr_pulse_cycles", 32'(cyc), 32'd2);
        next_step();
        wen = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!swe_n) found = 1'b1;
        end
        chk("rstwr_strobe_seen", 32'(found), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rstwr_swe_n", 32'(swe_n), 32'd1);
        chk("rstwr_sdq_oe", 32'(sdq_oe), 32'd0);
        chk("rstwr_soe_n", 32'(soe_n), 32'd1);
        chk("rstwr_ce", 32'(ce), 32'd0);
        next_step();
        rstn = 1'b1;
        exp_id.push_back(16'h90E9);
        wait_ce(cyc, soe_cnt, fsa);
        chk("rstwr_miss_cycles", 32'(cyc), 32'd4);
        chk("rstwr_miss_sa", fsa, 32'h10000);
        chk("rstwr_id", 32'(id), 32'(exp_id.pop_front()));
        next_step();
        wait_ce(cyc, soe_cnt, fsa);
        chk("rstwr_hit_cycles", 32'(cyc), 32'd2);
        chk("rstwr_no_hi", 32'(mem[18'h1D8FF]), 32'hDEAD);
        chk("rstwr_queue", 32'(exp_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
